g_3arb: RTL and testbench

//  Round-robin arbiter sharing one resource among three requesters; companion to
//  the g_3or combining macro. ANY is the 3-input OR of the requests.

---
 rtl/g_3arb_if.sv | 23 ++
 rtl/g_3arb.sv | 137 +++++++++++++
 tb/tb_g_3arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/g_3arb_if.sv
// Request/grant bundle between three requesters and the round-robin arbiter.
// The slave side is the arbiter; the master side is whoever drives the requests.
interface g_3arb_if;
    logic       a;
    logic       b;
    logic       c;
    logic       ga;
    logic       gb;
    logic       gc;
    logic [1:0] gid;
    logic       busy;
    logic       any;

    modport master (
        output a, b, c,
        input  ga, gb, gc, gid, busy, any
    );

    modport slave (
        input  a, b, c,
        output ga, gb, gc, gid, busy, any
    );
endinterface

// File: rtl/g_3arb.sv
// Three-way round-robin arbiter with registered one-hot grants, hold-while-requesting
// and optional forced rotation after MAXHOLD consecutive grant cycles.
module g_3arb #(
    parameter int unsigned MAXHOLD = 4,
    parameter int unsigned FIRST   = 0
) (
    input  logic       clk_i,
    input  logic       rn_i,
    g_3arb_if.slave    arb
);

    localparam int unsigned   HW        = (MAXHOLD < 1) ? 1 : $clog2(MAXHOLD + 1);
    localparam logic [1:0]    FIRST_IDX = 2'(FIRST);
    localparam logic [HW-1:0] HMAX      = HW'(MAXHOLD);
    localparam logic [HW-1:0] HONE      = HW'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    ptr_q,   ptr_d;
    logic [HW-1:0] hcnt_q,  hcnt_d;
    logic [2:0]    grant_q, grant_d;
    logic [1:0]    gid_q,   gid_d;
    logic          busy_q,  busy_d;

    logic [2:0]    req;
    logic [2:0]    others;
    logic          own_req;
    logic [2:0]    win_all;
    logic [2:0]    win_oth;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Returns {found, index} of the first set request in order p, p+1, p+2 (mod 3).
    function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        idx = p;
        for (int k = 0; k < 3; k++) begin
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
            idx = inc3(idx);
        end
        return res;
    endfunction

    assign req     = {arb.c, arb.b, arb.a};
    assign own_req = req[owner_q];
    assign others  = req & ~(3'b001 << owner_q);
    assign win_all = pick(req, ptr_q);
    assign win_oth = pick(others, ptr_q);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            IDLE: begin
                if (win_all[2]) begin
                    state_d = GRANT;
                    owner_d = win_all[1:0];
                    ptr_d   = inc3(win_all[1:0]);
                    hcnt_d  = HONE;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    if (win_oth[2]) begin
                        owner_d = win_oth[1:0];
                        ptr_d   = inc3(win_oth[1:0]);
                        hcnt_d  = HONE;
                    end else begin
                        state_d = IDLE;
                        hcnt_d  = '0;
                    end
                end else if (MAXHOLD == 0 || hcnt_q < HMAX) begin
                    if (hcnt_q != '1) begin
                        hcnt_d = hcnt_q + HONE;
                    end
                end else if (win_oth[2]) begin
                    owner_d = win_oth[1:0];
                    ptr_d   = inc3(win_oth[1:0]);
                    hcnt_d  = HONE;
                end else begin
                    // Nobody else waiting: keep the grant and open a fresh hold window.
                    hcnt_d = HONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        grant_d = 3'b000;
        gid_d   = 2'b11;
        busy_d  = 1'b0;
        if (state_d == GRANT) begin
            grant_d = 3'b001 << owner_d;
            gid_d   = owner_d;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            state_q <= IDLE;
            owner_q <= FIRST_IDX;
            ptr_q   <= FIRST_IDX;
            hcnt_q  <= '0;
            grant_q <= 3'b000;
            gid_q   <= 2'b11;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
        end
    end

    assign arb.ga   = grant_q[0];
    assign arb.gb   = grant_q[1];
    assign arb.gc   = grant_q[2];
    assign arb.gid  = gid_q;
    assign arb.busy = busy_q;
    assign arb.any  = arb.a | arb.b | arb.c;

endmodule

// File: tb/tb_g_3arb.sv
// Directed bench for g_3arb: a MAXHOLD=4 instance driven from a vector table and
// a MAXHOLD=0 instance for the unlimited-hold case, plus async reset and glitch cases.
module tb_g_3arb;

    logic clk;
    logic rst_n;

    g_3arb_if if4 ();
    g_3arb_if if0 ();

    g_3arb #(.MAXHOLD(4), .FIRST(0)) dut4 (.clk_i(clk), .rn_i(rst_n), .arb(if4));
    g_3arb #(.MAXHOLD(0), .FIRST(0)) dut0 (.clk_i(clk), .rn_i(rst_n), .arb(if0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [2:0] req;   // {C,B,A}
        logic [2:0] gnt;   // expected {GC,GB,GA}
        logic [1:0] gid;
    } vec_t;

    localparam int N = 34;
    vec_t tbl [N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive4(input logic [2:0] r);
        if4.a = r[0]; if4.b = r[1]; if4.c = r[2];
    endtask

    task automatic drive0(input logic [2:0] r);
        if0.a = r[0]; if0.b = r[1]; if0.c = r[2];
    endtask

    task automatic check4(input string tag, input logic [2:0] gnt, input logic [1:0] gid);
        chk({tag, "_gnt"}, int'({if4.gc, if4.gb, if4.ga}), int'(gnt));
        chk({tag, "_gid"}, int'(if4.gid), int'(gid));
        chk({tag, "_busy"}, int'(if4.busy), int'(gnt != 3'b000));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{3'b111, 3'b001, 2'd0};
        tbl[1]  = '{3'b111, 3'b001, 2'd0};
        tbl[2]  = '{3'b111, 3'b001, 2'd0};
        tbl[3]  = '{3'b111, 3'b001, 2'd0};
        tbl[4]  = '{3'b111, 3'b010, 2'd1};
        tbl[5]  = '{3'b111, 3'b010, 2'd1};
        tbl[6]  = '{3'b111, 3'b010, 2'd1};
        tbl[7]  = '{3'b111, 3'b010, 2'd1};
        tbl[8]  = '{3'b111, 3'b100, 2'd2};
        tbl[9]  = '{3'b111, 3'b100, 2'd2};
        tbl[10] = '{3'b111, 3'b100, 2'd2};
        tbl[11] = '{3'b111, 3'b100, 2'd2};
        tbl[12] = '{3'b111, 3'b001, 2'd0};
        tbl[13] = '{3'b000, 3'b000, 2'd3};
        tbl[14] = '{3'b010, 3'b010, 2'd1};   // one-cycle B pulse
        tbl[15] = '{3'b000, 3'b000, 2'd3};
        tbl[16] = '{3'b001, 3'b001, 2'd0};   // A held, C joins, A drops
        tbl[17] = '{3'b101, 3'b001, 2'd0};
        tbl[18] = '{3'b100, 3'b100, 2'd2};
        tbl[19] = '{3'b100, 3'b100, 2'd2};
        tbl[20] = '{3'b000, 3'b000, 2'd3};
        tbl[21] = '{3'b001, 3'b001, 2'd0};   // A alone: window restarts at MAXHOLD
        tbl[22] = '{3'b001, 3'b001, 2'd0};
        tbl[23] = '{3'b001, 3'b001, 2'd0};
        tbl[24] = '{3'b001, 3'b001, 2'd0};
        tbl[25] = '{3'b001, 3'b001, 2'd0};
        tbl[26] = '{3'b001, 3'b001, 2'd0};
        tbl[27] = '{3'b011, 3'b001, 2'd0};
        tbl[28] = '{3'b011, 3'b001, 2'd0};
        tbl[29] = '{3'b011, 3'b010, 2'd1};   // preempted after restarted window fills
        tbl[30] = '{3'b000, 3'b000, 2'd3};
        tbl[31] = '{3'b110, 3'b100, 2'd2};
        tbl[32] = '{3'b011, 3'b001, 2'd0};   // owner drops, search from PTR picks A
        tbl[33] = '{3'b000, 3'b000, 2'd3};

        // Reset held with all requests high
        rst_n = 1'b0;
        drive4(3'b111);
        drive0(3'b000);
        #12;
        check4("reset", 3'b000, 2'd3);
        chk("reset_any", int'(if4.any), 1);
        chk("reset_any0", int'(if0.any), 0);
        $display("reset: gnt=%b gid=%0d busy=%0d any=%0d", {if4.gc, if4.gb, if4.ga}, if4.gid, if4.busy, if4.any);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            drive4(tbl[i].req);
            tick();
            check4($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].gid);
            $display("vec%0d: req=%b gnt=%b exp=%b gid=%0d exp=%0d", i, tbl[i].req,
                     {if4.gc, if4.gb, if4.ga}, tbl[i].gnt, if4.gid, tbl[i].gid);
            drive4(3'b000);
        end

        // Glitch on B between edges while idle must not be sampled
        drive4(3'b010);
        #2;
        chk("glitch_any", int'(if4.any), 1);
        drive4(3'b000);
        tick();
        check4("glitch", 3'b000, 2'd3);
        $display("glitch: gnt=%b gid=%0d", {if4.gc, if4.gb, if4.ga}, if4.gid);

        // Unlimited hold: A and B both asserted for 20 cycles
        for (int i = 0; i < 20; i++) begin
            drive0(3'b011);
            tick();
            chk($sformatf("nohold%0d_gnt", i), int'({if0.gc, if0.gb, if0.ga}), 1);
            chk($sformatf("nohold%0d_gid", i), int'(if0.gid), 0);
            $display("nohold%0d: gnt=%b gid=%0d", i, {if0.gc, if0.gb, if0.ga}, if0.gid);
        end
        drive0(3'b010);
        tick();
        chk("nohold_handoff_gnt", int'({if0.gc, if0.gb, if0.ga}), 2);
        chk("nohold_handoff_gid", int'(if0.gid), 1);
        $display("nohold_handoff: gnt=%b gid=%0d", {if0.gc, if0.gb, if0.ga}, if0.gid);
        drive0(3'b000);
        tick();
        chk("nohold_idle_busy", int'(if0.busy), 0);

        // Async reset mid-grant: PTR points past B, so only a restored PTR yields A first
        drive4(3'b010);
        tick();
        check4("pre_rst", 3'b010, 2'd1);
        drive4(3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check4("async_rst", 3'b000, 2'd3);
        $display("async_rst: gnt=%b gid=%0d busy=%0d", {if4.gc, if4.gb, if4.ga}, if4.gid, if4.busy);
        #1;
        rst_n = 1'b1;
        tick();
        check4("post_rst", 3'b001, 2'd0);
        $display("post_rst: gnt=%b gid=%0d", {if4.gc, if4.gb, if4.ga}, if4.gid);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
